// File: rtl/mem_pkg.sv
// Shared types and constants for the data-port load/store sequencer.
// Exports mau_state_t, BYTE_W, DATA_ADDR_BITS and a byte-extend helper.
package mem_pkg;

  localparam int BYTE_W         = 8;
  localparam int DATA_ADDR_BITS = 13;

  typedef enum logic [1:0] {
    IDLE,
    B0,
    B1,
    FIN
  } mau_state_t;

  // Widen a loaded byte to a halfword, sign- or zero-filling the top.
  function automatic logic [2*BYTE_W-1:0] ext_byte(
    input logic              sgn,
    input logic [BYTE_W-1:0] b
  );
    ext_byte = {{BYTE_W{sgn & b[BYTE_W-1]}}, b};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response handshake plus byte-wide data-port bus.
// slave: the sequencer; master: the pipeline stage and memory side.
interface mem_access_unit_if #(
  parameter int WIDTH = 16
);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic             req_half;
  logic             req_signed;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;

  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;

  logic             mem_we;
  logic [WIDTH-1:0] mem_a2;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd2;

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_half,
    input  req_signed,
    input  req_addr,
    input  req_wdata,
    input  mem_rd2,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output mem_we,
    output mem_a2,
    output mem_wd
  );

  modport master (
    output req_valid,
    output req_we,
    output req_half,
    output req_signed,
    output req_addr,
    output req_wdata,
    output mem_rd2,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  mem_we,
    input  mem_a2,
    input  mem_wd
  );

endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: splits halfwords into two little-endian byte
// accesses on the data port and assembles/extends the load result.
// Ports: clk, rst (async, active high), bus (mem_access_unit_if.slave).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = DATA_ADDR_BITS
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  mau_state_t state;

  logic                  we_q;
  logic                  half_q;
  logic                  sgn_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [2*BYTE_W-1:0]   wdata_q;
  logic [BYTE_W-1:0]     lo_q;

  logic                  resp_valid_q;
  logic [WIDTH-1:0]      rdata_q;

  logic [ADDR_BITS-1:0]  addr_nx;
  logic [BYTE_W-1:0]     rd_byte;

  logic                  mem_we_c;
  logic [WIDTH-1:0]      mem_a2_c;
  logic [WIDTH-1:0]      mem_wd_c;

  // Upper address bits and the idle lanes of rd2 carry nothing.
  logic unused_bits;
  assign unused_bits = ^{bus.req_addr[WIDTH-1:ADDR_BITS],
                         bus.mem_rd2[WIDTH-1:BYTE_W]};

  // Wraps inside the data segment: 0x1FFF + 1 -> 0x0000.
  assign addr_nx = addr_q + ADDR_BITS'(1);
  assign rd_byte = bus.mem_rd2[BYTE_W-1:0];

  // Data-port drive depends only on state and latched request.
  always_comb begin
    mem_we_c = 1'b0;
    mem_a2_c = '0;
    mem_wd_c = '0;
    unique case (state)
      B0: begin
        mem_we_c = we_q;
        mem_a2_c = WIDTH'(addr_q);
        mem_wd_c = WIDTH'(wdata_q[BYTE_W-1:0]);
      end
      B1: begin
        mem_we_c = we_q;
        mem_a2_c = WIDTH'(addr_nx);
        mem_wd_c = WIDTH'(wdata_q[2*BYTE_W-1:BYTE_W]);
      end
      default: begin
        mem_we_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      half_q       <= 1'b0;
      sgn_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            half_q  <= bus.req_half;
            sgn_q   <= bus.req_signed;
            addr_q  <= bus.req_addr[ADDR_BITS-1:0];
            wdata_q <= bus.req_wdata[2*BYTE_W-1:0];
            state   <= B0;
          end
        end
        B0: begin
          state <= half_q ? B1 : FIN;
        end
        B1: begin
          // rd2 here is the reply to the B0 address.
          if (!we_q) begin
            lo_q <= rd_byte;
          end
          state <= FIN;
        end
        FIN: begin
          if (!we_q) begin
            if (half_q) begin
              rdata_q <= WIDTH'({rd_byte, lo_q});
            end else begin
              rdata_q <= WIDTH'(ext_byte(sgn_q, rd_byte));
            end
          end
          resp_valid_q <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_a2     = mem_a2_c;
  assign bus.mem_wd     = mem_wd_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-wide memory model.
// Vector table of load/store ops plus reset-abort sequence.
module tb_mem_access_unit;

  logic clk;
  logic rst;

  mem_access_unit_if #(.WIDTH(16)) bus ();

  mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data segment: 1-cycle read latency, one byte per access.
  logic [7:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a2[12:0]] <= bus.mem_wd[7:0];
    bus.mem_rd2 <= {8'h00, mem[bus.mem_a2[12:0]]};
  end

  typedef struct {
    logic        we;
    logic        half;
    logic        sgn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    bit          garb;
  } op_t;

  int          n_vec;
  int          n_bad;
  logic [15:0] last;

  task automatic chk1(string nm, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk16(string nm, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic busy_drive(bit g);
    if (g) begin
      bus.req_valid  = 1'($urandom_range(1));
      bus.req_we     = 1'($urandom_range(1));
      bus.req_half   = 1'($urandom_range(1));
      bus.req_signed = 1'($urandom_range(1));
      bus.req_addr   = 16'($urandom);
      bus.req_wdata  = 16'($urandom);
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge
  // of the resp_valid cycle so the next op is issued back-to-back.
  task automatic do_op(input op_t v);
    chk1("idle_ready", bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_half   = v.half;
    bus.req_signed = v.sgn;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(negedge clk);
    busy_drive(v.garb);
    chk1("b0_ready", bus.req_ready, 1'b0);
    chk1("b0_we", bus.mem_we, v.we);
    chk16("b0_a2", bus.mem_a2, v.addr & 16'h1FFF);
    chk16("b0_wd", bus.mem_wd, {8'h00, v.wdata[7:0]});
    chk1("b0_resp", bus.resp_valid, 1'b0);
    if (v.half) begin
      @(negedge clk);
      busy_drive(v.garb);
      chk1("b1_ready", bus.req_ready, 1'b0);
      chk1("b1_we", bus.mem_we, v.we);
      chk16("b1_a2", bus.mem_a2, (v.addr + 16'd1) & 16'h1FFF);
      chk16("b1_wd", bus.mem_wd, {8'h00, v.wdata[15:8]});
    end
    @(negedge clk);
    busy_drive(v.garb);
    chk1("fin_ready", bus.req_ready, 1'b0);
    chk1("fin_we", bus.mem_we, 1'b0);
    chk16("fin_a2", bus.mem_a2, 16'h0000);
    chk16("fin_wd", bus.mem_wd, 16'h0000);
    chk1("fin_resp", bus.resp_valid, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk1("resp_valid", bus.resp_valid, 1'b1);
    chk1("resp_ready", bus.req_ready, 1'b1);
    if (v.we) begin
      chk16("store_rdata", bus.resp_rdata, last);
    end else begin
      chk16("load_rdata", bus.resp_rdata, v.exp);
      last = v.exp;
    end
  endtask

  op_t vec [15];

  initial begin
    n_vec = 0;
    n_bad = 0;
    last  = 16'h0000;

    //        we    half  sgn   addr      wdata     exp       garb
    vec[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h3385, 16'h0000, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0085, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hFF85, 1'b0};
    vec[3]  = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'hBEEF, 16'h0000, 1'b0};
    vec[4]  = '{1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 1'b0, 16'h1FFF, 16'h1234, 16'h0000, 1'b0};
    vec[6]  = '{1'b0, 1'b1, 1'b0, 16'h1FFF, 16'h0000, 16'h1234, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0012, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 1'b0, 16'hE100, 16'h0000, 16'hBEEF, 1'b0};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 16'h0042, 16'h007F, 16'h0000, 1'b1};
    vec[10] = '{1'b0, 1'b0, 1'b1, 16'h0042, 16'h0000, 16'h007F, 1'b1};
    vec[11] = '{1'b0, 1'b0, 1'b0, 16'h0101, 16'h0000, 16'h00BE, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b1, 16'h0101, 16'h0000, 16'hFFBE, 1'b1};
    vec[13] = '{1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000, 16'h00BE, 1'b0};
    vec[14] = '{1'b1, 1'b0, 1'b0, 16'h0201, 16'hAA77, 16'h0000, 1'b0};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_half   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.req_wdata  = 16'h0000;

    // Byte 0x0102 is read by vec[13]; seed it through the DUT.
    @(negedge clk);
    chk1("rst_ready", bus.req_ready, 1'b1);
    chk1("rst_resp", bus.resp_valid, 1'b0);
    chk16("rst_rdata", bus.resp_rdata, 16'h0000);
    chk1("rst_we", bus.mem_we, 1'b0);
    chk16("rst_a2", bus.mem_a2, 16'h0000);
    chk16("rst_wd", bus.mem_wd, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    do_op('{1'b1, 1'b0, 1'b0, 16'h0102, 16'h0000, 16'h0000, 1'b0});

    for (int i = 0; i < 15; i++) begin
      do_op(vec[i]);
    end

    // Halfword store aborted by reset during B1.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_half  = 1'b1;
    bus.req_addr  = 16'h0200;
    bus.req_wdata = 16'hA55A;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk1("ab_b0_we", bus.mem_we, 1'b1);
    @(negedge clk);
    chk1("ab_b1_we", bus.mem_we, 1'b1);
    chk16("ab_b1_a2", bus.mem_a2, 16'h0201);
    rst = 1'b1;
    #1;
    chk1("ab_we", bus.mem_we, 1'b0);
    chk1("ab_ready", bus.req_ready, 1'b1);
    chk16("ab_a2", bus.mem_a2, 16'h0000);
    chk16("ab_rdata", bus.resp_rdata, 16'h0000);
    last = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("ab_no_resp", bus.resp_valid, 1'b0);
    end

    // Only the low byte landed; 0x0201 keeps the earlier 0x77.
    do_op('{1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h775A, 1'b0});

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
